// File: rtl/drp_rr_arbiter.sv
// Round-robin arbiter sharing one DRP master port between C_NUM_REQ DRP slave ports.
// One access outstanding at a time; a watchdog completes hung accesses with an error.
module drp_rr_arbiter #(
    parameter int unsigned C_NUM_REQ        = 4,
    parameter int unsigned C_DRP_ADDR_WIDTH = 12,
    parameter int unsigned C_DRP_DATA_WIDTH = 16,
    parameter int unsigned C_TIMEOUT        = 255
) (
    input  logic                                  M_DRPCLK,
    input  logic                                  M_DRPRST,
    input  logic [C_NUM_REQ-1:0]                  S_DRPEN,
    input  logic [C_NUM_REQ-1:0]                  S_DRPWE,
    input  logic [C_NUM_REQ*C_DRP_ADDR_WIDTH-1:0] S_DRPADDR,
    input  logic [C_NUM_REQ*C_DRP_DATA_WIDTH-1:0] S_DRPDI,
    output logic [C_NUM_REQ-1:0]                  S_DRPRDY,
    output logic [C_NUM_REQ-1:0]                  S_DRPERR,
    output logic [C_DRP_DATA_WIDTH-1:0]           S_DRPDO,
    output logic                                  M_DRPEN,
    output logic                                  M_DRPWE,
    output logic [C_DRP_ADDR_WIDTH-1:0]           M_DRPADDR,
    output logic [C_DRP_DATA_WIDTH-1:0]           M_DRPDI,
    input  logic                                  M_DRPRDY,
    input  logic [C_DRP_DATA_WIDTH-1:0]           M_DRPDO,
    output logic                                  BUSY,
    output logic [C_NUM_REQ-1:0]                  GRANT
);

    localparam int unsigned N       = C_NUM_REQ;
    localparam int unsigned AW      = C_DRP_ADDR_WIDTH;
    localparam int unsigned DW      = C_DRP_DATA_WIDTH;
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW      = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam int unsigned TLAST   = (C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0;
    localparam bit          WDOG_EN = (C_TIMEOUT != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    pend_q, pend_d;
    logic [N-1:0]    req_we_q, req_we_d;
    logic [N*AW-1:0] req_addr_q, req_addr_d;
    logic [N*DW-1:0] req_di_q, req_di_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            m_en_q, m_en_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_di_q, m_di_d;
    logic [N-1:0]    s_rdy_q, s_rdy_d;
    logic [N-1:0]    s_err_q, s_err_d;
    logic [DW-1:0]   s_do_q, s_do_d;
    logic            busy_q, busy_d;

    logic            arb_vld;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   cand;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_di;

    // First pending requester after the last-served one, wrapping N-1 -> 0.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(rr_q) + k) % N);
            if (!arb_vld && pend_q[cand]) begin
                arb_vld = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_di   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (IW'(i) == arb_idx) begin
                sel_we   = req_we_q[i];
                sel_addr = req_addr_q[i*AW +: AW];
                sel_di   = req_di_q[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_di_d   = req_di_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        timer_d    = timer_q;
        m_en_d     = 1'b0;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_di_d     = m_di_q;
        s_rdy_d    = '0;
        s_err_d    = '0;
        s_do_d     = '0;

        // A strobe on an already-pending requester keeps the original request.
        for (int unsigned i = 0; i < N; i++) begin
            if (S_DRPEN[i] && !pend_q[i]) begin
                pend_d[i]              = 1'b1;
                req_we_d[i]            = S_DRPWE[i];
                req_addr_d[i*AW +: AW] = S_DRPADDR[i*AW +: AW];
                req_di_d[i*DW +: DW]   = S_DRPDI[i*DW +: DW];
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Skip arbitration in the completion-pulse cycle so the owner can re-request.
                if (arb_vld && !(|s_rdy_q)) begin
                    state_d  = ST_ISSUE;
                    owner_d  = arb_idx;
                    grant_d  = N'(1) << arb_idx;
                    m_en_d   = 1'b1;
                    m_we_d   = sel_we;
                    m_addr_d = sel_addr;
                    m_di_d   = sel_di;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (M_DRPRDY || (WDOG_EN && (timer_q == TW'(TLAST)))) begin
                    s_rdy_d = grant_q;
                    if (M_DRPRDY) begin
                        s_do_d = M_DRPDO;
                    end else begin
                        s_err_d = grant_q;
                    end
                    pend_d  = pend_d & ~grant_q;
                    rr_d    = owner_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (WDOG_EN) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge M_DRPCLK) begin
        if (M_DRPRST) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            req_we_q   <= '0;
            req_addr_q <= '0;
            req_di_q   <= '0;
            rr_q       <= IW'(N - 1);
            owner_q    <= '0;
            grant_q    <= '0;
            timer_q    <= '0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_di_q     <= '0;
            s_rdy_q    <= '0;
            s_err_q    <= '0;
            s_do_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
            req_di_q   <= req_di_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            timer_q    <= timer_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_di_q     <= m_di_d;
            s_rdy_q    <= s_rdy_d;
            s_err_q    <= s_err_d;
            s_do_q     <= s_do_d;
            busy_q     <= busy_d;
        end
    end

    assign S_DRPRDY  = s_rdy_q;
    assign S_DRPERR  = s_err_q;
    assign S_DRPDO   = s_do_q;
    assign M_DRPEN   = m_en_q;
    assign M_DRPWE   = m_we_q;
    assign M_DRPADDR = m_addr_q;
    assign M_DRPDI   = m_di_q;
    assign BUSY      = busy_q;
    assign GRANT     = grant_q;

endmodule

// File: tb/tb_drp_rr_arbiter.sv
// Self-checking bench for drp_rr_arbiter: vector table, multi-requester sequences,
// watchdog, stray RDY and mid-transaction reset, checked through an expectation queue.
module tb_drp_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_en, s_we;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_di;
    logic [N-1:0]    s_rdy, s_err;
    logic [DW-1:0]   s_do;
    logic            m_en, m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_di;
    logic            m_rdy;
    logic [DW-1:0]   m_do;
    logic            busy;
    logic [N-1:0]    grant;

    drp_rr_arbiter #(
        .C_NUM_REQ(N), .C_DRP_ADDR_WIDTH(AW), .C_DRP_DATA_WIDTH(DW), .C_TIMEOUT(TO)
    ) dut (
        .M_DRPCLK(clk), .M_DRPRST(rst),
        .S_DRPEN(s_en), .S_DRPWE(s_we), .S_DRPADDR(s_addr), .S_DRPDI(s_di),
        .S_DRPRDY(s_rdy), .S_DRPERR(s_err), .S_DRPDO(s_do),
        .M_DRPEN(m_en), .M_DRPWE(m_we), .M_DRPADDR(m_addr), .M_DRPDI(m_di),
        .M_DRPRDY(m_rdy), .M_DRPDO(m_do),
        .BUSY(busy), .GRANT(grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int            idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
        int            iss;
        int            cmp;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        int            idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
        int            lat;
        logic          exp_err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] resp_of(input logic [AW-1:0] a);
        return {4'h0, a} ^ 16'hFFE6;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        return N'(1) << idx;
    endfunction

    // Expected transaction: issue cycle given, completion follows response latency or watchdog.
    task automatic push_exp(input int idx, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] di, input int iss, input int lat, input logic err);
        exp_t e;
        e.idx   = idx;
        e.we    = we;
        e.addr  = addr;
        e.di    = di;
        e.iss   = iss;
        e.cmp   = iss + (err ? int'(TO) + 1 : lat + 1);
        e.err   = err;
        e.rdata = (err || we) ? '0 : resp_of(addr);
        exp_q.push_back(e);
    endtask

    // DRP primitive model: RDY rdy_lat cycles after M_DRPEN (0 = never), read data from resp_of().
    int            rdy_lat = 2;
    int            cd = 0;
    logic [AW-1:0] r_addr;
    logic          r_we;
    int            stray_req = 0;
    int            stray_done = 0;

    initial begin
        m_rdy = 1'b0;
        m_do  = '0;
        forever begin
            @(negedge clk);
            m_rdy = 1'b0;
            m_do  = '0;
            if (rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        m_rdy = 1'b1;
                        m_do  = r_we ? '0 : resp_of(r_addr);
                    end
                end else if (stray_req != stray_done) begin
                    stray_done = stray_req;
                    m_rdy = 1'b1;
                    m_do  = 16'hDEAD;
                end
                if (m_en && rdy_lat > 0) begin
                    cd     = rdy_lat;
                    r_addr = m_addr;
                    r_we   = m_we;
                end
            end
        end
    end

    // Monitor: issues and completions are matched in order against the expectation queue.
    bit   iss_seen = 1'b0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                iss_seen = 1'b0;
            end else begin
                if (m_en) begin
                    if (exp_q.size() == 0 || iss_seen) begin
                        chk("unexpected_issue", 64'(m_en), 64'(0));
                    end else begin
                        mon_e = exp_q[0];
                        chk("iss_grant", 64'(grant), 64'(onehot(mon_e.idx)));
                        chk("iss_we", 64'(m_we), 64'(mon_e.we));
                        chk("iss_addr", 64'(m_addr), 64'(mon_e.addr));
                        chk("iss_di", 64'(m_di), 64'(mon_e.di));
                        chk("iss_cycle", 64'(cyc), 64'(mon_e.iss));
                        chk("iss_busy", 64'(busy), 64'(1));
                    end
                    iss_seen = 1'b1;
                end
                if (s_rdy != '0) begin
                    if (exp_q.size() == 0 || !iss_seen) begin
                        chk("unexpected_rdy", 64'(s_rdy), 64'(0));
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("cmp_rdy", 64'(s_rdy), 64'(onehot(mon_e.idx)));
                        chk("cmp_err", 64'(s_err), 64'(mon_e.err ? onehot(mon_e.idx) : '0));
                        chk("cmp_do", 64'(s_do), 64'(mon_e.rdata));
                        chk("cmp_cycle", 64'(cyc), 64'(mon_e.cmp));
                    end
                    iss_seen = 1'b0;
                end else begin
                    chk("idle_do", 64'(s_do), 64'(0));
                    chk("idle_err", 64'(s_err), 64'(0));
                end
                if (!busy) chk("idle_grant", 64'(grant), 64'(0));
            end
        end
    end

    task automatic strobe(input logic [N-1:0] en, input logic [N-1:0] we,
                          input logic [N*AW-1:0] addr, input logic [N*DW-1:0] di);
        s_en   = en;
        s_we   = we;
        s_addr = addr;
        s_di   = di;
        @(negedge clk);
        s_en = '0;
    endtask

    task automatic req_one(input int idx, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] di);
        logic [N-1:0]    en;
        logic [N-1:0]    wm;
        logic [N*AW-1:0] fa;
        logic [N*DW-1:0] fd;
        en = '0;
        wm = '0;
        fa = '0;
        fd = '0;
        en[idx] = 1'b1;
        wm[idx] = we;
        fa[idx*AW +: AW] = addr;
        fd[idx*DW +: DW] = di;
        strobe(en, wm, fa, fd);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int              c;
        logic [N-1:0]    wm;
        logic [N*AW-1:0] fa;
        logic [N*DW-1:0] fd;

        vecs[0] = '{1, 1'b1, 12'h004, 16'h5A5A, 3,  1'b0};
        vecs[1] = '{0, 1'b0, 12'h008, 16'h1234, 1,  1'b0};
        vecs[2] = '{3, 1'b0, 12'hFFF, 16'h0000, 2,  1'b0};
        vecs[3] = '{2, 1'b1, 12'h123, 16'h0000, 5,  1'b0};
        vecs[4] = '{0, 1'b1, 12'h000, 16'hFFFF, 1,  1'b0};
        vecs[5] = '{2, 1'b0, 12'h800, 16'h0001, 0,  1'b1};
        vecs[6] = '{3, 1'b0, 12'h7AB, 16'h0002, 16, 1'b0};
        vecs[7] = '{1, 1'b0, 12'h055, 16'h0003, 17, 1'b1};

        rst    = 1'b1;
        s_en   = '0;
        s_we   = '0;
        s_addr = '0;
        s_di   = '0;
        repeat (4) @(negedge clk);
        chk("rst_outputs", 64'({m_en, m_we, m_addr, m_di, s_rdy, s_err, s_do, busy, grant}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // All four strobe together: served 0,1,2,3 from the reset pointer.
        rdy_lat = 2;
        wm = 4'b1010;
        for (int i = 0; i < int'(N); i++) begin
            fa[i*AW +: AW] = AW'(12'h100 + i);
            fd[i*DW +: DW] = DW'(16'hA000 + i);
        end
        c = cyc;
        for (int k = 0; k < int'(N); k++)
            push_exp(k, wm[k], fa[k*AW +: AW], fd[k*DW +: DW], c + 2 + k * 5, 2, 1'b0);
        strobe(4'hF, wm, fa, fd);
        wait_idle(200);

        // Requesters 0 and 3 together after 3 was last served: 0 then 3.
        for (int i = 0; i < int'(N); i++) begin
            fa[i*AW +: AW] = AW'(12'h200 + i);
            fd[i*DW +: DW] = DW'(16'hB000 + i);
        end
        wm = 4'b0000;
        c = cyc;
        push_exp(0, 1'b0, fa[0*AW +: AW], fd[0*DW +: DW], c + 2, 2, 1'b0);
        push_exp(3, 1'b0, fa[3*AW +: AW], fd[3*DW +: DW], c + 7, 2, 1'b0);
        strobe(4'b1001, wm, fa, fd);
        wait_idle(200);

        // Requester 0 re-requests in its own completion cycle: it waits behind 1,2,3.
        for (int i = 0; i < int'(N); i++) begin
            fa[i*AW +: AW] = AW'(12'h300 + i);
            fd[i*DW +: DW] = DW'(16'hC000 + i);
        end
        wm = 4'b0101;
        c = cyc;
        for (int k = 0; k < int'(N); k++)
            push_exp(k, wm[k], fa[k*AW +: AW], fd[k*DW +: DW], c + 2 + k * 5, 2, 1'b0);
        strobe(4'hF, wm, fa, fd);
        while (cyc < c + 5) @(negedge clk);
        chk("rereq_pulse", 64'(s_rdy), 64'(onehot(0)));
        push_exp(0, 1'b1, 12'h3F0, 16'h0F0F, c + 22, 2, 1'b0);
        req_one(0, 1'b1, 12'h3F0, 16'h0F0F);
        wait_idle(200);

        // Isolated transactions, including watchdog and RDY on the last WAIT cycle.
        for (int v = 0; v < 8; v++) begin
            rdy_lat = vecs[v].lat;
            c = cyc;
            push_exp(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].di, c + 2,
                     vecs[v].lat, vecs[v].exp_err);
            req_one(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].di);
            wait_idle(100);
        end

        // Stray RDY while idle must not produce a completion.
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_busy", 64'(busy), 64'(0));

        // Repeated strobes from a pending requester keep the first address.
        rdy_lat = 4;
        c = cyc;
        push_exp(2, 1'b0, 12'h0A0, 16'h00A0, c + 2, 4, 1'b0);
        req_one(2, 1'b0, 12'h0A0, 16'h00A0);
        req_one(2, 1'b1, 12'h0B0, 16'h00B0);
        req_one(2, 1'b1, 12'h0C0, 16'h00C0);
        wait_idle(100);
        repeat (10) @(negedge clk);

        // Reset during WAIT: aborted access and the other pending request vanish.
        rdy_lat = 0;
        c = cyc;
        push_exp(0, 1'b0, 12'h010, 16'h0010, c + 2, 0, 1'b1);
        wm = '0;
        fa = '0;
        fd = '0;
        fa[0*AW +: AW] = 12'h010;
        fd[0*DW +: DW] = 16'h0010;
        fa[1*AW +: AW] = 12'h011;
        fd[1*DW +: DW] = 16'h0011;
        strobe(4'b0011, wm, fa, fd);
        while (cyc < c + 5) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_outputs", 64'({m_en, m_we, m_addr, m_di, s_rdy, s_err, s_do, busy, grant}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'(0));

        // Fresh request after reset is served normally.
        rdy_lat = 2;
        c = cyc;
        push_exp(3, 1'b0, 12'h3C3, 16'h0000, c + 2, 2, 1'b0);
        req_one(3, 1'b0, 12'h3C3, 16'h0000);
        wait_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
